// File: rtl/el2_regfile_snap_fifo.sv
// Snapshot FIFO: captures trig-qualified copies of the register bundle and streams them out word by word.
// Latency: a snapshot captured on a trig edge is presented (header word) from the following cycle.
// Backpressure: out_ready low stalls the stream with data held stable; a full FIFO drops or overwrites new snapshots.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   clear               synchronous flush of FIFO contents, sequence number and drop counter
//   trig, regs_i        capture request and the NREG*XLEN register bundle sampled with it
//   out_valid/out_ready stream handshake
//   out_data/out_idx    current word (idx 0 = header seq, idx k = register k-1)
//   out_last            final word of the snapshot (idx == NREG)
//   level/full/empty    occupancy status
//   drop_cnt            saturating count of dropped or overwritten snapshots
module el2_regfile_snap_fifo #(
  parameter int XLEN      = 32,
  parameter int NREG      = 26,
  parameter int DEPTH     = 4,
  parameter int OVERWRITE = 0,
  parameter int DCNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         trig,
  input  logic [NREG*XLEN-1:0]         regs_i,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_data,
  output logic [$clog2(NREG+1)-1:0]    out_idx,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty,
  output logic [DCNT_W-1:0]            drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int IW = $clog2(NREG+1);
  localparam int LW = $clog2(DEPTH+1);

  // Each entry holds the header word followed by the NREG register words.
  logic [XLEN-1:0]   r_mem [DEPTH][NREG+1];

  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [LW-1:0]     r_level;
  logic [IW-1:0]     r_idx;
  logic [31:0]       r_seq;
  logic [DCNT_W-1:0] r_drop;

  logic              w_empty;
  logic              w_full;
  logic              w_beat;
  logic              w_last;
  logic              w_pop;
  logic              w_started;
  logic              w_acc;
  logic              w_ovr;
  logic              w_wr;
  logic              w_lost;
  logic [XLEN-1:0]   w_hdr;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_beat  = !w_empty && out_ready;
  assign w_last  = (r_idx == IW'(NREG));
  assign w_pop   = w_beat && w_last;

  // The head counts as being streamed once its header handshake has happened,
  // including a header beat in this very cycle; such an entry is never replaced.
  assign w_started = (r_idx != '0) || w_beat;

  // Accept when there is room, or when the final-word pop frees a slot this cycle.
  assign w_acc  = trig && !clear && (!w_full || w_pop);
  // Overwrite-oldest: only while full and the head has not started streaming.
  assign w_ovr  = trig && !clear && w_full && !w_pop && (OVERWRITE != 0) && !w_started;
  assign w_wr   = w_acc || w_ovr;
  // Every snapshot that is not accepted as extra occupancy is lost to the consumer.
  assign w_lost = trig && !clear && !w_acc;

  // Header is the sequence number, zero-extended or truncated to XLEN.
  always_comb begin
    w_hdr = '0;
    for (int b = 0; b < XLEN && b < 32; b++) begin
      w_hdr[b] = r_seq[b];
    end
  end

  // Storage carries no reset; only the control state does.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_tail][0] <= w_hdr;
      for (int k = 0; k < NREG; k++) begin
        r_mem[r_tail][k+1] <= regs_i[k*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
      r_idx   <= '0;
      r_seq   <= '0;
      r_drop  <= '0;
    end else if (clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
      r_idx   <= '0;
      r_seq   <= '0;
      r_drop  <= '0;
    end else begin
      if (trig) begin
        r_seq <= r_seq + 32'd1;
      end
      if (w_wr) begin
        r_tail <= r_tail + PW'(1);
      end
      // Head moves on a final-word pop, or when the oldest entry is overwritten.
      if (w_pop || w_ovr) begin
        r_head <= r_head + PW'(1);
      end
      if (w_acc && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (!w_acc && w_pop) begin
        r_level <= r_level - LW'(1);
      end
      if (w_beat) begin
        r_idx <= w_last ? '0 : r_idx + IW'(1);
      end
      if (w_lost && (r_drop != '1)) begin
        r_drop <= r_drop + DCNT_W'(1);
      end
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = out_valid ? r_mem[r_head][r_idx] : '0;
  assign out_idx   = out_valid ? r_idx : '0;
  assign out_last  = out_valid && w_last;
  assign level     = r_level;
  assign full      = w_full;
  assign empty     = w_empty;
  assign drop_cnt  = r_drop;

endmodule
